// File: rtl/pipe_rca_addsub.sv
// pipe_rca_addsub: pipelined ripple-carry adder/subtractor.
// The WIDTH-bit carry chain is cut into SEG-bit ripple segments, one register
// stage per segment. Upper operand bits travel forward in skew registers, and
// finished lower sum bits travel forward in deskew registers. The full sum and
// its flags therefore leave the final stage aligned.
module pipe_rca_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;

  logic             stall;
  logic             in_fire;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // A held result freezes the whole pipeline. Bubbles are kept, not squeezed out.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign in_fire  = in_valid & in_ready;

  // Subtraction folds into addition: a - b - cin == a + ~b + ~cin
  assign b_eff = sub ? ~b : b;
  assign c_eff = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * SEG;
    localparam int OPW = WIDTH - LO;

    logic [OPW-1:0]    xin;
    logic [OPW-1:0]    yin;
    logic              cin_s;
    logic              vin;
    logic [SEG-1:0]    sseg;
    logic              cseg;
    logic [LO+SEG-1:0] snext;
    logic [LO+SEG-1:0] sq;
    logic              cq;
    logic              vq;

    if (k == 0) begin : g_src
      assign xin   = a;
      assign yin   = b_eff;
      assign cin_s = c_eff;
      assign vin   = in_fire;
      assign snext = sseg;
    end else begin : g_src
      assign xin   = stg[k-1].g_skew.xq;
      assign yin   = stg[k-1].g_skew.yq;
      assign cin_s = stg[k-1].cq;
      assign vin   = stg[k-1].vq;
      assign snext = {sseg, stg[k-1].sq};
    end

    // Ripple this stage's segment with the carry that the previous stage registered
    always_comb begin
      logic carry;
      carry = cin_s;
      sseg  = '0;
      for (int i = 0; i < SEG; i++) begin
        sseg[i] = xin[i] ^ yin[i] ^ carry;
        carry   = (xin[i] & yin[i]) | (carry & (xin[i] ^ yin[i]));
      end
      cseg = carry;
    end

    // Register the segment sum, the accumulated lower bits, the carry-out and the valid bit
    always_ff @(posedge clk) begin
      if (rst) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else if (!stall) begin
        vq <= vin;
        cq <= cseg;
        sq <= snext;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [OPW-SEG-1:0] xq;
      logic [OPW-SEG-1:0] yq;

      // Carry the operand bits not yet summed forward to the next segment
      always_ff @(posedge clk) begin
        if (rst) begin
          xq <= '0;
          yq <= '0;
        end else if (!stall) begin
          xq <= xin[OPW-1:SEG];
          yq <= yin[OPW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic ovfq;
      logic zeroq;

      // Overflow uses the carry into the MSB, recovered from the MSB sum bit; zero uses the complete sum
      always_ff @(posedge clk) begin
        if (rst) begin
          ovfq  <= 1'b0;
          zeroq <= 1'b0;
        end else if (!stall) begin
          ovfq  <= (xin[SEG-1] ^ yin[SEG-1] ^ sseg[SEG-1]) ^ cseg;
          zeroq <= ~|snext;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vq;
  assign sum       = stg[STAGES-1].sq;
  assign cout      = stg[STAGES-1].cq;
  assign ovf       = stg[STAGES-1].g_flags.ovfq;
  assign zero      = stg[STAGES-1].g_flags.zeroq;

endmodule
